alu_iter_unit: RTL and testbench

ALU_ITER_UNIT -- requirements
Module: alu_iter_unit

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_unit_if.sv | 27 ++
 rtl/alu_comb_core.sv | 30 +++
 rtl/alu_iter_unit.sv | 105 ++++++++++
 tb/tb_alu_iter_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the iterative ALU and its
// control decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_unit_if.sv
// Request/result bundle of the iterative ALU.
// Handshake: a request transfers on the rising edge where i_valid && o_ready;
// a result transfers on the rising edge where o_valid && i_ready. The producer
// holds its payload stable while valid is high and not yet accepted.
interface alu_iter_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [3:0]            i_alu_control;
  logic [DATA_WIDTH-1:0] i_src_a;
  logic [DATA_WIDTH-1:0] i_src_b;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_zero;

  modport slave (
    input  i_valid, i_alu_control, i_src_a, i_src_b, i_ready,
    output o_ready, o_valid, o_result, o_zero
  );

  modport master (
    output i_valid, i_alu_control, i_src_a, i_src_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero
  );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle combinational datapath. Shift opcodes pass operand A through:
// that is the zero-shift result, real shifts are iterated by the parent.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  always_comb begin
    o_result = i_a + i_b;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = DATA_WIDTH'($signed(i_a) < $signed(i_b));
      OP_SLTU: o_result = DATA_WIDTH'(i_a < i_b);
      OP_SLL, OP_SRL, OP_SRA: o_result = i_a;
      // Unassigned codes fall back to ADD.
      default: o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_iter_unit.sv
// Iterative ALU: one-cycle ops through alu_comb_core, shifts performed one bit
// per cycle in a working register, result held until the consumer takes it.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_iter_unit_if.slave  bus,
  output state_t          dbg_state
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   core_result;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    accept;

  alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_op     (bus.i_alu_control),
    .i_a      (bus.i_src_a),
    .i_b      (bus.i_src_b),
    .o_result (core_result)
  );

  assign shamt  = bus.i_src_b[SHAMT_WIDTH-1:0];
  assign accept = bus.i_valid && (state_q == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'b0000;
      result_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    shifted  = shift_q;

    // One-bit step of the latched shift op; SRA replicates the sign bit,
    // which never changes while shifting right.
    case (op_q)
      OP_SLL:  shifted = {shift_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, shift_q[DATA_WIDTH-1:1]};
      OP_SRA:  shifted = {shift_q[DATA_WIDTH-1], shift_q[DATA_WIDTH-1:1]};
      default: shifted = shift_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = bus.i_alu_control;
          if (is_shift_op(bus.i_alu_control) && (shamt != '0)) begin
            shift_d = bus.i_src_a;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else begin
            result_d = core_result;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        shift_d = shifted;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_valid  = (state_q == ST_DONE);
  assign bus.o_result = result_q;
  assign bus.o_zero   = (result_q == '0);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit: reference model of results and latency,
// a per-cycle result checker, backpressure and reset-abort scenarios.
module tb_alu_iter_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  alu_iter_unit_if #(.DATA_WIDTH(W)) bus ();

  alu_iter_unit #(.DATA_WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_result(input logic [3:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return a >> sh;
      4'd9: return $signed(a) >>> sh;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    if ((op == 4'd5 || op == 4'd8 || op == 4'd9) && sh > 0) return sh + 1;
    return 1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- per-cycle result checker ----------------
  always @(negedge clk) begin
    if (rst_n && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("result", bus.o_result, exp_q[0]);
        check("zero", {31'd0, bus.o_zero}, {31'd0, exp_q[0] == '0});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk); #1;
    while (bus.o_ready !== 1'b1 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 20) check("ready_timeout", {31'd0, bus.o_ready}, 32'd1);
    bus.i_valid       = 1'b1;
    bus.i_alu_control = op;
    bus.i_src_a       = a;
    bus.i_src_b       = b;
    exp_q.push_back(model_result(op, a, b));
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the unit must have latched them.
    bus.i_valid       = 1'b0;
    bus.i_alu_control = 4'($urandom_range(0, 15));
    bus.i_src_a       = $urandom;
    bus.i_src_b       = $urandom;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    @(negedge clk); #1;
    while (bus.o_valid !== 1'b1 && cycles < 100) begin
      @(negedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lit, input int hold);
    int cycles;
    send(op, a, b);
    wait_valid(cycles);
    check({name, "_latency"}, 32'(cycles), 32'(model_latency(op, b)));
    check({name, "_literal"}, bus.o_result, lit);
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, {31'd0, bus.o_valid}, 32'd1);
      check({name, "_hold_ready"}, {31'd0, bus.o_ready}, 32'd0);
      @(negedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    bus.i_ready = 1'b0;
    check({name, "_post_valid"}, {31'd0, bus.o_valid}, 32'd0);
    check({name, "_post_ready"}, {31'd0, bus.o_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lit;
    int           hold;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cycles;

    vecs[0]  = '{"add",       4'b0000, 32'd7,          32'd5,          32'd12,         0};
    vecs[1]  = '{"sub_zero",  4'b0001, 32'd5,          32'd5,          32'd0,          0};
    vecs[2]  = '{"sra4",      4'b1001, 32'h8000_0000,  32'd4,          32'hF800_0000,  0};
    vecs[3]  = '{"srl4",      4'b1000, 32'h8000_0000,  32'd4,          32'h0800_0000,  0};
    vecs[4]  = '{"sll31",     4'b0101, 32'd1,          32'd31,         32'h8000_0000,  0};
    vecs[5]  = '{"slt",       4'b0110, 32'hFFFF_FFFF,  32'd1,          32'd1,          0};
    vecs[6]  = '{"sltu",      4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd0,          0};
    vecs[7]  = '{"code_c",    4'b1100, 32'd3,          32'd4,          32'd7,          0};
    vecs[8]  = '{"and_bp",    4'b0010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  10};
    vecs[9]  = '{"or",        4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  0};
    vecs[10] = '{"xor",       4'b0100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  0};
    vecs[11] = '{"sll_sh0",   4'b0101, 32'h0000_1234,  32'd32,         32'h0000_1234,  0};
    vecs[12] = '{"add_wrap",  4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,          0};
    vecs[13] = '{"sub_wrap",  4'b0001, 32'd0,          32'd1,          32'hFFFF_FFFF,  0};
    vecs[14] = '{"sra31",     4'b1001, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  3};
    vecs[15] = '{"code_f",    4'b1111, 32'd10,         32'd20,         32'd30,         0};

    bus.i_valid       = 1'b0;
    bus.i_ready       = 1'b0;
    bus.i_alu_control = 4'd0;
    bus.i_src_a       = '0;
    bus.i_src_b       = '0;
    rst_n             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, bus.o_ready}, 32'd1);
    check("rst_valid",  {31'd0, bus.o_valid}, 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    check("rst_zero",   {31'd0, bus.o_zero}, 32'd1);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lit, vecs[i].hold);

    // Reset during a long shift: accepted at edge 0, reset sampled at edge 8.
    send(4'b0101, 32'd1, 32'd20);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_shift_valid",  {31'd0, bus.o_valid}, 32'd0);
    check("rst_shift_result", bus.o_result, 32'd0);
    check("rst_shift_state",  32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_shift_ready", {31'd0, bus.o_ready}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      check("rst_shift_no_result", {31'd0, bus.o_valid}, 32'd0);
      @(negedge clk); #1;
    end

    // Reset while a result is waiting in DONE.
    send(4'b0000, 32'd2, 32'd3);
    wait_valid(cycles);
    check("done_latency", 32'(cycles), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    rst_n = 1'b1;
    check("rst_done_valid",  {31'd0, bus.o_valid}, 32'd0);
    check("rst_done_result", bus.o_result, 32'd0);
    check("rst_done_ready",  {31'd0, bus.o_ready}, 32'd1);

    // Reset coinciding with a request: the request must be dropped.
    @(negedge clk); #1;
    rst_n             = 1'b0;
    bus.i_valid       = 1'b1;
    bus.i_alu_control = 4'b0000;
    bus.i_src_a       = 32'd1;
    bus.i_src_b       = 32'd1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst_n       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_req_dropped", {31'd0, bus.o_valid}, 32'd0);
      @(negedge clk); #1;
    end
    check("rst_req_ready", {31'd0, bus.o_ready}, 32'd1);

    // Normal operation resumes after the aborts.
    run_vec("after_rst", 4'b1000, 32'hF000_000F, 32'd3, 32'h1E00_0001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
